multicyc_mem_bridge: RTL and testbench
======================================

// Module: multicyc_mem_bridge
// PURPOSE
//  Memory-side neighbour of the multicycle control unit: accepts its one-cycle mem_rd/mem_wr
//  strobes (instr fetch and data access share one port), runs a req/ack transaction on the
//  external memory bus, and holds the CPU with cpu_stall until done. Houses the memory data
//  register (MDR) feeding IR and the writeback mux. Detects misaligned access and bus timeout.
// PARAMETERS
//  ADDR_W    32  byte-address width
//  DATA_W    32  data word width
//  MAX_WAIT  15  cycles in REQ with bus_ack low before abort (>=1)
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  reset_n    in   1       asynchronous, active-low reset
//  cpu_rd     in   1       read strobe from control unit
//  cpu_wr     in   1       write strobe from control unit
//  cpu_addr   in   ADDR_W  byte address (PC or ALUout, selected upstream)
//  cpu_wdata  in   DATA_W  store data (Rt)
//  cpu_rdata  out  DATA_W  MDR: last successfully read word
//  cpu_stall  out  1       control unit must hold its state and outputs while 1
//  cpu_err    out  1       sticky error flag (misalign/timeout/rd&wr), cleared by reset only
//  bus_req    out  1       registered request, held until ack or abort
//  bus_we     out  1       1=write, 0=read; stable while bus_req
//  bus_addr   out  ADDR_W  word address, stable while bus_req
//  bus_wdata  out  DATA_W  stable while bus_req
//  bus_ack    in   1       one-cycle completion; ignored unless state==REQ
//  bus_rdata  in   DATA_W  valid in the bus_ack cycle for reads
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; bus_req, bus_we, cpu_err, wait counter = 0;
//   bus_addr, bus_wdata, cpu_rdata = 0. cpu_stall=0 (comb from IDLE, no strobe).
//  States: IDLE, REQ, DONE (2-bit encoding; unused code -> IDLE).
//  IDLE: on cpu_rd|cpu_wr latch addr/wdata/we (cpu_wr wins if both; both also sets cpu_err).
//   aligned (addr[1:0]==0): -> REQ, bus_req<=1. misaligned: no bus cycle, cpu_err<=1 -> DONE.
//  REQ: bus_req=1. bus_ack=1 -> bus_req<=0; read: cpu_rdata<=bus_rdata; -> DONE.
//   else counter++; counter==MAX_WAIT-1 with no ack -> abort: bus_req<=0, cpu_err<=1,
//   cpu_rdata unchanged, -> DONE. Counter cleared on REQ entry.
//  DONE: one cycle, stall=0 so control unit advances on this edge; strobes in DONE are the
//   same held request and are ignored; -> IDLE unconditionally.
//  cpu_stall = (IDLE & (cpu_rd|cpu_wr)) | REQ  (combinational, Mealy in IDLE).
//  Latency: strobe at cycle T -> bus_req from T+1 -> ack earliest T+1 -> DONE T+2;
//   minimum 2 stall cycles per access; cpu_rdata valid from DONE cycle until next read ack.
//  bus_ack in same edge as abort threshold: ack wins (normal completion, no error).
//  Back-to-back: new strobe in the cycle after DONE starts a fresh transaction from IDLE.
//  Reset mid-REQ: bus_req drops immediately (async); memory must tolerate abandoned request.
// TESTING
//  1 read, ack 1 cycle after req: cpu_rd=1 addr=0x10, bus_rdata=0xCAFEF00D -> stall 1,1,0;
//    bus_addr=0x10, bus_we=0; cpu_rdata=0xCAFEF00D in DONE; cpu_err=0.
//  2 write, ack after 4 cycles: cpu_wr addr=0x20 wdata=0x12345678 -> bus_we=1, addr/wdata
//    stable 4 cycles; stall low exactly one cycle after ack; cpu_rdata unchanged.
//  3 no ack, MAX_WAIT=15 -> bus_req high 15 cycles then 0; cpu_err=1 sticky; DONE reached;
//    next read with ack completes normally, cpu_err stays 1 until reset_n pulse.
//  4 misaligned cpu_rd addr=0x13 -> bus_req never asserted; stall 1 cycle; cpu_err=1.
//  5 cpu_rd=cpu_wr=1 addr=0x30 -> write transaction issued (bus_we=1), cpu_err=1.
//  6 reset_n low mid-REQ (async, between edges) -> bus_req/cpu_stall drop same cycle;
//    after release, stray bus_ack in IDLE ignored; cpu_rdata=0.

Source files
------------

// File: rtl/multicyc_mem_bridge.sv
// Memory bridge for the multicycle control unit. It turns one-cycle read/write
// strobes into a req/ack bus transaction, stalls the CPU until that transaction
// ends, holds the MDR, and sets a sticky error flag.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | no access in flight; a strobe latches the request (stall is Mealy)
//   REQ   | bus_req high, waiting for bus_ack or the wait limit
//   DONE  | one cycle with stall low so the control unit advances
module multicyc_mem_bridge #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  // The wait counter only has to reach MAX_WAIT-1.
  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_err_q, cpu_err_d;

  // State and datapath registers. Reset clears everything at once, so a
  // request that is in flight is simply abandoned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      cpu_rdata_q <= '0;
      cpu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_err_q   <= cpu_err_d;
    end
  end

  // Next-state logic, register updates and the combinational stall output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_err_d   = cpu_err_q;
    cpu_stall   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_rd || cpu_wr) begin
          cpu_stall   = 1'b1;
          bus_addr_d  = cpu_addr;
          bus_wdata_d = cpu_wdata;
          // A write wins when both strobes are asserted; the conflict is flagged.
          bus_we_d    = cpu_wr;
          cnt_d       = '0;
          if (cpu_rd && cpu_wr) cpu_err_d = 1'b1;
          if (cpu_addr[1:0] == 2'b00) begin
            bus_req_d = 1'b1;
            state_d   = REQ;
          end else begin
            // A misaligned access never reaches the bus.
            cpu_err_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      REQ: begin
        cpu_stall = 1'b1;
        // An ack wins over the abort when both happen on the same edge.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) cpu_rdata_d = bus_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_req_d = 1'b0;
          cpu_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // The control unit still holds the same strobe here, so it is ignored.
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_err   = cpu_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_multicyc_mem_bridge.sv
// Testbench for multicyc_mem_bridge. The expected results come from
// transaction-level rules: how many stall and request cycles each access takes,
// when the MDR is updated, and when the sticky error flag is set.
module tb_multicyc_mem_bridge;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_err;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_rdata;
  logic        exp_err;

  multicyc_mem_bridge #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .cpu_err   (cpu_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
  endtask

  // Runs one access. The task is entered at a falling edge with the DUT idle.
  // d is the index of the REQ cycle in which the bus acks; if d >= MAX_WAIT the
  // bus never acks. With hold set, the strobe stays asserted through the DONE edge.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int d, input logic hold);
    logic        mis, tmo, done;
    int          n_stall, n_req, exp_req, exp_stall;
    logic [31:0] rd_val;
    mis       = (addr[1:0] != 2'b00);
    tmo       = !mis && (d >= MAX_WAIT);
    exp_req   = mis ? 0 : (tmo ? MAX_WAIT : d + 1);
    exp_stall = mis ? 1 : exp_req + 1;
    rd_val    = $urandom;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    n_stall = 0; n_req = 0; done = 1'b0;
    for (int it = 0; it < MAX_WAIT + 8 && !done; it++) begin
      #1;
      if (!cpu_stall) done = 1'b1;
      else begin
        n_stall++;
        if (bus_req) begin
          chk("bus_addr", bus_addr, addr);
          chk("bus_we", {31'b0, bus_we}, {31'b0, wr});
          chk("bus_wdata", bus_wdata, wdata);
          bus_ack   = (n_req == d);
          bus_rdata = (n_req == d) ? rd_val : $urandom;
          n_req++;
        end else begin
          bus_ack   = 1'b0;
          bus_rdata = $urandom;
        end
        @(negedge clk);
        bus_ack = 1'b0;
      end
    end
    chk("stall_bound", {31'b0, done}, 32'd1);
    if (!mis && !tmo && !wr) exp_rdata = rd_val;
    exp_err = exp_err | (rd & wr) | mis | tmo;
    chk("n_stall", n_stall, exp_stall);
    chk("n_req", n_req, exp_req);
    chk("bus_req_done", {31'b0, bus_req}, 32'd0);
    chk("cpu_rdata", cpu_rdata, exp_rdata);
    chk("cpu_err", {31'b0, cpu_err}, {31'b0, exp_err});
    if (hold) begin
      @(negedge clk);
      #1;
      cpu_rd = 1'b0; cpu_wr = 1'b0;
      #1;
      chk("done_ignore_req", {31'b0, bus_req}, 32'd0);
      chk("done_ignore_stall", {31'b0, cpu_stall}, 32'd0);
    end else begin
      cpu_rd = 1'b0; cpu_wr = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        rd, wr, hold;
    logic [31:0] a, w;
    int          sel, d;
    reset_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    exp_rdata = '0; exp_err = 1'b0;
    #2;
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'b0, bus_we}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_cpu_err", {31'b0, cpu_err}, 32'd0);
    chk("rst_cpu_stall", {31'b0, cpu_stall}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    chk("t1_mdr", cpu_rdata, exp_rdata);
    do_access(1'b0, 1'b1, 32'h20, 32'h12345678, 3, 1'b1);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, MAX_WAIT + 5, 1'b0);
    do_access(1'b1, 1'b0, 32'h44, 32'h0, 1, 1'b0);
    do_access(1'b1, 1'b0, 32'h13, 32'h0, 0, 1'b0);
    do_access(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 2, 1'b0);
    do_access(1'b1, 1'b0, 32'h48, 32'h0, MAX_WAIT - 1, 1'b0);
    do_access(1'b0, 1'b1, 32'h4C, 32'h0BADBEEF, MAX_WAIT - 1, 1'b1);

    // Random accesses
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 9);
      rd  = (sel < 5) || (sel == 9);
      wr  = (sel >= 5);
      a   = $urandom;
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      else a[1:0] = 2'b00;
      w   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) d = MAX_WAIT - 1;
      else if (sel == 1) d = MAX_WAIT + 1;
      else d = $urandom_range(0, 4);
      hold = 1'($urandom_range(0, 1));
      do_access(rd, wr, a, w, d, hold);
    end

    // Asynchronous reset while a request is in flight
    cpu_rd = 1'b1; cpu_addr = 32'h50;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("pre_rst_req", {31'b0, bus_req}, 32'd1);
    reset_n = 1'b0; cpu_rd = 1'b0;
    #1;
    exp_rdata = '0; exp_err = 1'b0;
    chk("arst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("arst_stall", {31'b0, cpu_stall}, 32'd0);
    chk("arst_err", {31'b0, cpu_err}, 32'd0);
    chk("arst_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("stray_ack_req", {31'b0, bus_req}, 32'd0);
    chk("stray_ack_rdata", cpu_rdata, 32'd0);
    chk("stray_ack_stall", {31'b0, cpu_stall}, 32'd0);
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'h60, 32'h0, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
